// File: rtl/pimc_rx.sv
// Receive endpoint for interrupt-controller messages: acknowledges messages aimed at
// CPU_ID and queues their line numbers for the core. Define PIMC_RX_BROADCAST_EN to also accept pid 8'hFF.
module pimc_rx #(
    parameter logic [7:0] CPU_ID     = 8'h00,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             notify,
    input  logic [7:0]                       lineno,
    input  logic [7:0]                       processor_id,
    output logic                             irqack,
    output logic                             irq_pending,
    output logic [7:0]                       irq_line,
    input  logic                             core_claim,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  pend_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACK     = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    head_q, head_d;
    logic          irqack_q, irqack_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          id_match;
    logic          push;
    logic          pop;

    always_comb begin
`ifdef PIMC_RX_BROADCAST_EN
        id_match = (processor_id == CPU_ID) || (processor_id == 8'hFF);
`else
        id_match = (processor_id == CPU_ID);
`endif
        // Full check uses the pre-edge count, so a same-cycle pop never frees a slot early.
        push = (state_q == IDLE) && !notify && id_match && (count_q < DEPTH_C);
        pop  = core_claim && (count_q != '0);

        state_d = state_q;
        case (state_q)
            IDLE:    if (push) state_d = ACK;
            ACK:     state_d = RELEASE;
            RELEASE: if (notify) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        irqack_d = (state_d == ACK);

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // The head output is registered, so it is computed from the post-edge queue contents;
        // a push landing exactly at the new head is forwarded from lineno.
        if (count_d == '0) begin
            head_d = 8'h00;
        end else if (push && (rd_ptr_d == wr_ptr_q)) begin
            head_d = lineno;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= 8'h00;
            irqack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            irqack_q <= irqack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= lineno;
        end
    end

    assign irqack      = irqack_q;
    assign irq_pending = (count_q != '0);
    assign irq_line    = head_q;
    assign pend_count  = count_q;

endmodule

// File: tb/tb_pimc_rx.sv
// Scoreboard bench for pimc_rx: a queue-level reference model predicts every cycle's
// outputs and a negedge monitor compares them against the DUT.
module tb_pimc_rx;

    localparam logic [7:0] CPU   = 8'h02;
    localparam int         DEPTH = 4;
    localparam int         CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          notify = 1'b1;
    logic [7:0]    lineno = 8'h00;
    logic [7:0]    processor_id = 8'h00;
    logic          irqack;
    logic          irq_pending;
    logic [7:0]    irq_line;
    logic          core_claim = 1'b0;
    logic [CW-1:0] pend_count;

    int tests = 0;
    int fails = 0;
    int claim_pct = 0;
    logic force_claim = 1'b0;

    typedef struct {
        bit         ack;
        bit         pend;
        logic [7:0] line;
        int         cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_q[$];

    pimc_rx #(.CPU_ID(CPU), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .notify(notify), .lineno(lineno),
        .processor_id(processor_id), .irqack(irqack), .irq_pending(irq_pending),
        .irq_line(irq_line), .core_claim(core_claim), .pend_count(pend_count)
    );

    always #10 clk = ~clk;

    function automatic bit pid_match(input logic [7:0] p);
`ifdef PIMC_RX_BROADCAST_EN
        return (p == CPU) || (p == 8'hFF);
`else
        return (p == CPU);
`endif
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a message is taken once per offer (accepted, then blocked until the
    // controller lets notify go high after the ack cycle); the queue is a plain FIFO.
    initial begin : model
        bit   push, pop;
        bit   busy;
        bit   ack_cycle;
        exp_t e;
        busy = 0;
        ack_cycle = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_q.delete();
                exp_q.delete();
                busy = 0;
                ack_cycle = 0;
            end else begin
                pop  = core_claim && (model_q.size() > 0);
                push = !busy && !notify && pid_match(processor_id) && (model_q.size() < DEPTH);
                if (ack_cycle) ack_cycle = 0;
                else if (busy && notify) busy = 0;
                if (push) begin
                    busy = 1;
                    ack_cycle = 1;
                end
                if (pop) void'(model_q.pop_front());
                if (push) model_q.push_back(lineno);
                e.ack  = push;
                e.cnt  = model_q.size();
                e.pend = (model_q.size() > 0);
                e.line = (model_q.size() > 0) ? model_q[0] : 8'h00;
                exp_q.push_back(e);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("irqack", int'(irqack), int'(e.ack));
                check("irq_pending", int'(irq_pending), int'(e.pend));
                check("irq_line", int'(irq_line), int'(e.line));
                check("pend_count", int'(pend_count), e.cnt);
            end
        end
    end

    initial begin : claimer
        forever begin
            @(posedge clk);
            #2;
            core_claim = force_claim || ((claim_pct > 0) && ($urandom_range(0, 99) < claim_pct));
        end
    end

    task automatic wait_ack(input string name);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!irqack && w < 400);
        if (!irqack) begin
            tests++;
            fails++;
            $display("FAIL %s: no irqack within %0d cycles at %0t", name, w, $time);
        end
    endtask

    task automatic release_msg(input int gap);
        @(posedge clk);
        #1 notify = 1'b1;
        repeat (gap + 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic offer(input logic [7:0] ln, input logic [7:0] pid, input int hold, input int gap);
        lineno = ln;
        processor_id = pid;
        notify = 1'b0;
        if (pid_match(pid)) wait_ack("ack_wait");
        repeat (hold) @(posedge clk);
        release_msg(gap);
    endtask

    task automatic drain();
        claim_pct = 100;
        repeat (DEPTH + 4) @(posedge clk);
        #1 claim_pct = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int w;
        int r;
        logic [7:0] pid;
        #1 rst_n = 1'b0;
        #4;
        check("rst_irqack", int'(irqack), 0);
        check("rst_pending", int'(irq_pending), 0);
        check("rst_line", int'(irq_line), 0);
        check("rst_count", int'(pend_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single message, then claim it
        offer(8'd5, CPU, 0, 1);
        force_claim = 1'b1;
        @(posedge clk);
        #1 force_claim = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // mismatched processor id, held low ten cycles
        offer(8'd17, 8'd3, 10, 1);

        // held after ack, then a second distinct message
        offer(8'd3, CPU, 5, 0);
        offer(8'd7, CPU, 0, 1);
        drain();

        // full queue backpressure, one claim frees a slot
        for (int i = 1; i <= 4; i++) offer(8'(i), CPU, 0, 0);
        lineno = 8'd9;
        processor_id = CPU;
        notify = 1'b0;
        repeat (5) @(posedge clk);
        #1 force_claim = 1'b1;
        @(posedge clk);
        #1 force_claim = 1'b0;
        wait_ack("full_ack");
        release_msg(1);
        check("full_head", int'(irq_line), 2);
        check("full_count", int'(pend_count), 4);
        drain();

        // claim and matching push on the same edge
        offer(8'd21, CPU, 0, 0);
        offer(8'd22, CPU, 0, 0);
        lineno = 8'd23;
        processor_id = CPU;
        notify = 1'b0;
        force_claim = 1'b1;
        @(posedge clk);
        #1 force_claim = 1'b0;
        wait_ack("simul_ack");
        release_msg(1);
        drain();

        // broadcast id, accepted only when the broadcast build is selected
        offer(8'd40, 8'hFF, 4, 1);
        drain();

        // reset while acknowledging with three entries queued
        for (int i = 31; i <= 33; i++) offer(8'(i), CPU, 0, 0);
        lineno = 8'd34;
        processor_id = CPU;
        notify = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!irqack && w < 50);
        check("ack_before_rst", int'(irqack), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_irqack", int'(irqack), 0);
        check("midrst_count", int'(pend_count), 0);
        check("midrst_pending", int'(irq_pending), 0);
        check("midrst_line", int'(irq_line), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ack("post_rst_ack");
        release_msg(1);
        check("post_rst_count", int'(pend_count), 1);
        check("post_rst_line", int'(irq_line), 34);
        drain();

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            if (i % 25 == 0) claim_pct = $urandom_range(15, 60);
            r = $urandom_range(0, 5);
            case (r)
                0, 1, 2: pid = CPU;
                3:       pid = 8'd3;
                4:       pid = 8'hFF;
                default: pid = 8'($urandom_range(0, 255));
            endcase
            offer(8'($urandom_range(1, 255)), pid, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        drain();
        check("final_count", int'(pend_count), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pimc_rx.md
PIMC_RX -- requirements
Module: pimc_rx

Interface
REQ-001 SHALL have parameter CPU_ID, default 8'h00: processor ID this endpoint answers to.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: pending-line queue depth, power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock, 50 MHz; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port notify  input  1  active-low message valid from interrupt controller; low = lineno/processor_id valid.
REQ-006 SHALL have port lineno  input  8  interrupt line number of offered message.
REQ-007 SHALL have port processor_id  input  8  target processor of offered message.
REQ-008 SHALL have port irqack  output  1  one-cycle acknowledge to controller; releases the message.
REQ-009 SHALL have port irq_pending  output  1  high while queue non-empty; core interrupt request.
REQ-010 SHALL have port irq_line  output  8  line number at queue head; 8'h00 when empty.
REQ-011 SHALL have port core_claim  input  1  one-cycle pulse from core popping queue head.
REQ-012 SHALL have port pend_count  output  $clog2(FIFO_DEPTH+1)  number of queued entries.

Function
REQ-013 SHALL implement FSM states IDLE, ACK, RELEASE; registered state, one transition per clk edge.
REQ-014 SHALL, in IDLE, capture when notify==0, processor_id==CPU_ID, and pend_count<FIFO_DEPTH (sampled at same edge): push lineno, go to ACK.
REQ-015 SHALL ignore messages with non-matching processor_id: no push, no irqack, stay IDLE.
REQ-016 SHALL, when matching message arrives with queue full, stay IDLE without ack (backpressure); controller holds message; capture occurs first edge a slot is free.
REQ-017 SHALL drive irqack high exactly the one cycle the FSM is in ACK; ACK -> RELEASE unconditionally.
REQ-018 SHALL remain in RELEASE, ignoring notify, until notify sampled 1, then go to IDLE; a message never captured twice.
REQ-019 SHALL give latency: matching message sampled at edge N -> entry visible (irq_pending, irq_line, pend_count) and irqack high after edge N.
REQ-020 SHALL pop head on core_claim when pend_count>0; core_claim when empty ignored, no state change.
REQ-021 SHALL, on simultaneous push and pop, keep pend_count unchanged, head advances, new entry at tail.
REQ-022 SHALL evaluate full check with pre-edge pend_count; pop in same cycle does not enable push when full.
REQ-023 SHALL keep queue FIFO order; read/write pointers log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH.
REQ-024 SHALL register irq_pending, irq_line, pend_count, irqack; no combinational path from inputs to outputs.

Reset
REQ-025 SHALL on rst_n low immediately force: state IDLE, irqack 0, irq_pending 0, irq_line 8'h00, pend_count 0, pointers 0.
REQ-026 SHALL discard queued entries and any in-flight ack on reset mid-operation; message still held low after reset deasserts is captured as new.
REQ-027 SHALL resume operation first clk edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with PIMC_RX_BROADCAST_EN defined, also accept processor_id==8'hFF as match for any CPU_ID (same capture/ack rules).
REQ-029 SHALL, without PIMC_RX_BROADCAST_EN, accept only processor_id==CPU_ID; 8'hFF treated as non-matching unless CPU_ID==8'hFF.

Verification
REQ-030 Single: CPU_ID=2, notify=0, lineno=5, pid=2, held until ack -> irqack one cycle, irq_pending=1, irq_line=5, pend_count=1; claim -> pend_count=0, irq_line=0.
REQ-031 Mismatch: CPU_ID=2, pid=3, notify low 10 cycles -> irqack never high, pend_count=0.
REQ-032 Full: DEPTH=4, lines 1,2,3,4 queued, line 9 offered -> no irqack; claim once -> line 9 acked next cycle, head=2, pend_count=4.
REQ-033 Hold-off: notify kept low 5 cycles after ack -> single push, pend_count=1; notify high then low with line 7 -> second push.
REQ-034 Simultaneous: pend_count=2, claim with new matching message same edge -> pend_count=2, order preserved.
REQ-035 Reset: rst_n low in ACK with 3 entries -> irqack 0 and pend_count 0 without clock edge; broadcast pid=8'hFF accepted only with PIMC_RX_BROADCAST_EN.
